hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard scoreboard for the pipelined processor; replaces the hardwired-zero `stall` with real interlocks. Sits beside the decode stage: tracks every in-flight register write with a per-register countdown of cycles until the result can be forwarded. Stalls decode when a source, or optionally a destination, is still pending. Handles the single-cycle load-use case and multi-cycle FPU latencies uniformly, and keeps a saturating stall-cycle counter for performance bring-up.

## Interface
Parameters:
- `NREGS`, 64, number of tracked registers (32 integer + 32 FP, matching the 6-bit write address)
- `AW`, 6, register address width; must satisfy 2^AW >= NREGS
- `CW`, 3, countdown width; maximum encodable latency is 2^CW-1
- `SW`, 32, stall-cycle counter width

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `issue_valid`  in  1  decode holds a valid instruction this cycle
- `issue_we`  in  1  instruction writes a register
- `issue_rd`  in  AW  destination register
- `issue_lat`  in  CW  cycles until result forwardable to decode; 0 = forwardable next cycle, no tracking
- `src1_used`, `src2_used`  in  1 each  source operand is read
- `src1_addr`, `src2_addr`  in  AW each  source registers
- `flush`  in  1  squash the instruction in decode (branch/jump redirect)
- `stall`  out  1  hold fetch/decode, insert bubble into execute (combinational)
- `busy`  out  1  some counter nonzero (registered)
- `stall_cycles`  out  SW  saturating count of cycles with `stall`=1

## Operation
- State: `cnt[r]`, CW bits, r = 0..NREGS-1; `stall_cycles`.
- Register 0 is hardwired zero: never tracked, never causes a hazard.
- Hazard per source i: `srci_used & srci_addr!=0 & cnt[srci_addr]!=0`.
- `stall = issue_valid & !flush & (hazard1 | hazard2 | waw)`; `waw` is 0 unless the configuration feature is enabled.
- Issue accepted when `issue_valid & !flush & !stall`.
- Record: on an accepted issue with `issue_we`, `issue_rd!=0` and `issue_lat!=0`, `cnt[issue_rd] <= issue_lat`.
- Every other counter decrements by 1 when nonzero and holds at 0. The counter just written by a record does not also decrement that cycle; the record overrides.
- Stalled or flushed instruction: nothing recorded; all counters still decrement.
- `flush` forces `stall`=0 in the same cycle.
- `stall_cycles` increments when `stall`=1 and saturates at all-ones.
- Unused addresses (r >= NREGS) read as 0.

## Timing
- Reset (`reset`=0, asynchronous): all `cnt` = 0, `busy` = 0, `stall_cycles` = 0. `stall` is then 0 because no counter is pending.
- Latency: a producer accepted at cycle t with `issue_lat`=L gives `cnt`=L at t+1 and `cnt`=0 at t+1+L.
  - A dependent instruction presented at t+1 stalls exactly L cycles and is accepted at t+1+L.
  - Load-use uses L=1, giving one bubble.
- `stall` is combinational from inputs and current counters; it has no dependency on itself.
- `busy` is updated at each edge from the next-state counters.
- Reset asserted mid-stall clears all pending state immediately. After release, the first edge sees an empty scoreboard.

## Configuration
- `SCOREBOARD_WAW_EN` defined: `waw = issue_we & issue_rd!=0 & cnt[issue_rd] > issue_lat`.
  - A short-latency write cannot overtake a pending long-latency write to the same register, so results are never clobbered out of order.
- Undefined: `waw` = 0. A later write simply overwrites the counter, which is correct only if the writeback order equals the issue order.

## Test plan
- Reset: hold `reset`=0 with random inputs -> `stall`=0, `busy`=0, `stall_cycles`=0; release -> `stall`=0 for an independent instruction stream.
- Load-use: issue rd=5, lat=1 at t; at t+1 present src1=5 -> `stall`=1 at t+1 only, accepted at t+2, `stall_cycles`=1.
- FPU latency: issue rd=40, lat=4; next instruction uses src2=40 -> 4 stall cycles; `busy` falls after the 4th; the same sequence with src2=0 or src2_used=0 -> no stall.
- Flush: with cnt[7]=3, present src1=7 and `flush`=1 -> `stall`=0, nothing recorded, cnt[7] reads 2 next cycle.
- Record override: cnt[9]=1 while issuing rd=9, lat=3 -> cnt[9]=3 next cycle, not 0 or 2; issue with rd=0, lat=5 -> `busy` stays 0.
- WAW (`SCOREBOARD_WAW_EN` defined): cnt[12]=5, issue rd=12, lat=1 -> `stall`=1 until cnt[12]<=1, then accepted.
  - Same stimulus with the macro undefined -> accepted immediately, cnt[12]=1.
- Saturation: with SW=4, force 20 consecutive stall cycles -> `stall_cycles`=15 and holds at 15.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: per-register countdown of cycles until a result is forwardable.
// Define SCOREBOARD_WAW_EN to also stall a write that would overtake a longer pending write.
module hazard_scoreboard #(
    parameter int NREGS = 64,
    parameter int AW    = 6,
    parameter int CW    = 3,
    parameter int SW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_valid,
    input  logic          issue_we,
    input  logic [AW-1:0] issue_rd,
    input  logic [CW-1:0] issue_lat,
    input  logic          src1_used,
    input  logic [AW-1:0] src1_addr,
    input  logic          src2_used,
    input  logic [AW-1:0] src2_addr,
    input  logic          flush,
    output logic          stall,
    output logic          busy,
    output logic [SW-1:0] stall_cycles
);

    logic [CW-1:0] cnt     [NREGS];
    logic [CW-1:0] cnt_nxt [NREGS];
    logic [CW-1:0] cnt_ext [2**AW];
    logic          hazard1;
    logic          hazard2;
    logic          waw;
    logic          accept;
    logic          record;
    logic          busy_nxt;

    // Addresses beyond NREGS read as an empty counter.
    for (genvar g = 0; g < 2**AW; g++) begin : g_ext
        if (g < NREGS) begin : g_used
            assign cnt_ext[g] = cnt[g];
        end else begin : g_unused
            assign cnt_ext[g] = '0;
        end
    end

    assign hazard1 = src1_used && (src1_addr != '0) && (cnt_ext[src1_addr] != '0);
    assign hazard2 = src2_used && (src2_addr != '0) && (cnt_ext[src2_addr] != '0);

`ifdef SCOREBOARD_WAW_EN
    assign waw = issue_we && (issue_rd != '0) && (cnt_ext[issue_rd] > issue_lat);
`else
    assign waw = 1'b0;
`endif

    assign stall  = issue_valid && !flush && (hazard1 || hazard2 || waw);
    assign accept = issue_valid && !flush && !stall;
    assign record = accept && issue_we && (issue_rd != '0) && (issue_lat != '0);

    // A fresh record replaces the decrement for its own register.
    always_comb begin
        busy_nxt = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            if (record && (issue_rd == AW'(r))) begin
                cnt_nxt[r] = issue_lat;
            end else if (cnt[r] != '0) begin
                cnt_nxt[r] = cnt[r] - CW'(1);
            end else begin
                cnt_nxt[r] = '0;
            end
            busy_nxt = busy_nxt | (cnt_nxt[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt[r] <= '0;
            end
            busy         <= 1'b0;
            stall_cycles <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            busy <= busy_nxt;
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (CW=5 so a 20-cycle stall is reachable, SW=4 to saturate).
module tb_hazard_scoreboard;

    localparam int NREGS = 64;
    localparam int AW    = 6;
    localparam int CW    = 5;
    localparam int SW    = 4;

    logic          clk;
    logic          reset;
    logic          issue_valid;
    logic          issue_we;
    logic [AW-1:0] issue_rd;
    logic [CW-1:0] issue_lat;
    logic          src1_used;
    logic [AW-1:0] src1_addr;
    logic          src2_used;
    logic [AW-1:0] src2_addr;
    logic          flush;
    logic          stall;
    logic          busy;
    logic [SW-1:0] stall_cycles;

    int n_cmp  = 0;
    int n_fail = 0;
    int n;

    hazard_scoreboard #(.NREGS(NREGS), .AW(AW), .CW(CW), .SW(SW)) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_we     (issue_we),
        .issue_rd     (issue_rd),
        .issue_lat    (issue_lat),
        .src1_used    (src1_used),
        .src1_addr    (src1_addr),
        .src2_used    (src2_used),
        .src2_addr    (src2_addr),
        .flush        (flush),
        .stall        (stall),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic we, input int rd, input int lat,
                       input logic s1u, input int s1a, input logic s2u, input int s2a,
                       input logic fl);
        issue_valid = v;
        issue_we    = we;
        issue_rd    = AW'(rd);
        issue_lat   = CW'(lat);
        src1_used   = s1u;
        src1_addr   = AW'(s1a);
        src2_used   = s2u;
        src2_addr   = AW'(s2a);
        flush       = fl;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after driving; returns with the instruction about to be accepted.
    task automatic count_stalls(output int cnt);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (!stall) break;
            cnt++;
            tick();
        end
        if (cnt >= 40) chk("stall_timeout", cnt, 0);
    endtask

    initial begin
        reset = 1'b0;
        drv($urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(63, 0),
            $urandom_range(31, 0), 1'b1, $urandom_range(63, 1), 1'b1,
            $urandom_range(63, 1), 1'b0);
        #3;
        chk("rst_stall", int'(stall), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sc", int'(stall_cycles), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            drv(1'b1, 1'b1, $urandom_range(63, 1), $urandom_range(31, 1), 1'b1,
                $urandom_range(63, 1), 1'b1, $urandom_range(63, 1), 1'b0);
        end
        #1;
        chk("rst_hold_stall", int'(stall), 0);
        chk("rst_hold_busy", int'(busy), 0);
        tick();
        reset = 1'b1;
        idle();

        // Independent stream with zero-latency writes
        drv(1'b1, 1'b1, 3, 0, 1'b1, 1, 1'b1, 2, 1'b0);
        #1 chk("indep_a", int'(stall), 0);
        tick();
        drv(1'b1, 1'b1, 4, 0, 1'b1, 3, 1'b1, 0, 1'b0);
        #1 chk("indep_b", int'(stall), 0);
        tick();
        chk("indep_busy", int'(busy), 0);

        // Load-use
        drv(1'b1, 1'b1, 5, 1, 1'b0, 0, 1'b0, 0, 1'b0);
        tick();
        chk("lu_busy", int'(busy), 1);
        drv(1'b1, 1'b0, 0, 0, 1'b1, 5, 1'b0, 0, 1'b0);
        count_stalls(n);
        chk("lu_stalls", n, 1);
        chk("lu_sc", int'(stall_cycles), 1);
        tick();
        idle();

        // FPU latency
        drv(1'b1, 1'b1, 40, 4, 1'b0, 0, 1'b0, 0, 1'b0);
        tick();
        drv(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b1, 40, 1'b0);
        count_stalls(n);
        chk("fpu_stalls", n, 4);
        chk("fpu_busy_fall", int'(busy), 0);
        chk("fpu_sc", int'(stall_cycles), 5);
        tick();
        drv(1'b1, 1'b1, 40, 4, 1'b0, 0, 1'b0, 0, 1'b0);
        tick();
        drv(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b1, 0, 1'b0);
        #1 chk("fpu_src0", int'(stall), 0);
        tick();
        drv(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 40, 1'b0);
        #1 chk("fpu_unused", int'(stall), 0);
        tick();
        idle();
        for (int k = 0; k < 3; k++) tick();
        chk("fpu_drain_busy", int'(busy), 0);

        // Flush: cnt[7]=3, flushed write to 7 is dropped
        drv(1'b1, 1'b1, 7, 4, 1'b0, 0, 1'b0, 0, 1'b0);
        tick();
        idle();
        tick();
        drv(1'b1, 1'b1, 7, 6, 1'b1, 7, 1'b0, 0, 1'b1);
        #1 chk("flush_stall", int'(stall), 0);
        tick();
        drv(1'b1, 1'b0, 0, 0, 1'b1, 7, 1'b0, 0, 1'b0);
        count_stalls(n);
        chk("flush_cnt2", n, 2);
        tick();
        idle();

        // Record override: cnt[9]=1 rewritten to 3
        drv(1'b1, 1'b1, 9, 2, 1'b0, 0, 1'b0, 0, 1'b0);
        tick();
        idle();
        tick();
        drv(1'b1, 1'b1, 9, 3, 1'b0, 0, 1'b0, 0, 1'b0);
        #1 chk("ovr_issue", int'(stall), 0);
        tick();
        drv(1'b1, 1'b0, 0, 0, 1'b1, 9, 1'b0, 0, 1'b0);
        count_stalls(n);
        chk("ovr_cnt3", n, 3);
        chk("ovr_sc", int'(stall_cycles), 10);
        tick();
        drv(1'b1, 1'b1, 0, 5, 1'b0, 0, 1'b0, 0, 1'b0);
        tick();
        chk("rd0_busy", int'(busy), 0);
        drv(1'b1, 1'b0, 0, 0, 1'b1, 0, 1'b1, 0, 1'b0);
        #1 chk("rd0_src", int'(stall), 0);
        tick();
        idle();

        // WAW: cnt[12]=5 then a lat=1 write to 12
        drv(1'b1, 1'b1, 12, 5, 1'b0, 0, 1'b0, 0, 1'b0);
        tick();
        drv(1'b1, 1'b1, 12, 1, 1'b0, 0, 1'b0, 0, 1'b0);
        count_stalls(n);
`ifdef SCOREBOARD_WAW_EN
        chk("waw_stalls", n, 4);
`else
        chk("waw_stalls", n, 0);
`endif
        tick();
        drv(1'b1, 1'b0, 0, 0, 1'b1, 12, 1'b0, 0, 1'b0);
        count_stalls(n);
        chk("waw_cnt1", n, 1);
`ifdef SCOREBOARD_WAW_EN
        chk("waw_sc", int'(stall_cycles), 15);
`else
        chk("waw_sc", int'(stall_cycles), 11);
`endif
        tick();
        idle();

        // Saturation over 20 consecutive stalls, then mid-stall reset
        #2 reset = 1'b0;
        #1 chk("sat_rst_sc", int'(stall_cycles), 0);
        tick();
        reset = 1'b1;
        drv(1'b1, 1'b1, 20, 20, 1'b0, 0, 1'b0, 0, 1'b0);
        tick();
        drv(1'b1, 1'b0, 0, 0, 1'b1, 20, 1'b0, 0, 1'b0);
        for (int k = 0; k < 15; k++) tick();
        chk("sat_15", int'(stall_cycles), 15);
        for (int k = 0; k < 5; k++) tick();
        chk("sat_hold", int'(stall_cycles), 15);
        #1 chk("sat_still_stall", int'(stall), 0);
        tick();
        chk("sat_after", int'(stall_cycles), 15);
        drv(1'b1, 1'b1, 21, 10, 1'b0, 0, 1'b0, 0, 1'b0);
        tick();
        drv(1'b1, 1'b0, 0, 0, 1'b1, 21, 1'b0, 0, 1'b0);
        tick();
        #1 chk("mid_stall_pre", int'(stall), 1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_stall", int'(stall), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_sc", int'(stall_cycles), 0);
        tick();
        reset = 1'b1;
        #1 chk("post_rst_stall", int'(stall), 0);
        tick();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
